anton_neopixel_receiver: RTL and testbench
==========================================

// Module: anton_neopixel_receiver
// PURPOSE
//  WS2812-style single-wire decoder: samples a NeoPixel data line on clk6_4mhz, classifies bits by high-pulse width,
//  assembles MSB-first bytes and writes them sequentially into a pixel buffer through a simple write port.
//  Line-low >= RESET_DELAY ticks delimits frames. Used for loopback self-test of the NeoPixel transmitter
//  and for chaining a downstream controller that consumes a pixel stream.
// PARAMETERS
//  BUFFER_END   `BUFFER_END_DEFAULT  last writable byte address (buffer size BUFFER_END+1)
//  RESET_DELAY  320                  line-low ticks recognised as sync/frame end (50us @ 6.4MHz)
//  THRESHOLD    4                    high ticks >= THRESHOLD decode as 1, else 0
//  MAX_HIGH     12                   high ticks reaching MAX_HIGH = timing error
//  localparam BUFFER_BITS = `CLOG2(BUFFER_END+1)
// PORTS
//  clk6_4mhz    in   1            sole clock, 6.4MHz (tick = 156.25ns)
//  reset        in   1            asynchronous, active-high reset
//  enable       in   1            0 forces WAIT_SYNC, no writes
//  neoData      in   1            asynchronous NeoPixel data line
//  wr_en        out  1            one-cycle byte write strobe
//  wr_addr      out  BUFFER_BITS  byte address, 0 at frame start
//  wr_data      out  8            decoded byte, MSB received first
//  frame_done   out  1            one-cycle pulse at frame end
//  frame_len    out  BUFFER_BITS+1 bytes written in last completed frame
//  err_timing   out  1            high pulse >= MAX_HIGH in current/last frame
//  err_partial  out  1            frame ended with 1..7 bits pending
//  err_overflow out  1            bytes arrived past BUFFER_END
//  busy         out  1            1 in HIGH or LOW states
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, state WAIT_SYNC. Reset mid-frame discards partial byte; no frame_done.
//  Input: 2-flop synchroniser -> neo_s; neo_d = neo_s delayed 1 cycle; rise = ~neo_d&neo_s, fall = neo_d&~neo_s.
//  States: WAIT_SYNC, IDLE, HIGH, LOW.
//   WAIT_SYNC: low_cnt counts cycles neo_s==0 (cleared when 1); at low_cnt==RESET_DELAY-1 -> IDLE. Bits ignored.
//   IDLE: rise -> HIGH, high_cnt=1, bit_cnt=0, byte_cnt=0, clear all err_* flags.
//   HIGH: high_cnt++ (saturating); fall -> shift bit (high_cnt>=THRESHOLD) into shift reg, bit_cnt++, low_cnt=1, -> LOW.
//         high_cnt==MAX_HIGH -> err_timing=1, discard partial byte, no frame_done, -> WAIT_SYNC.
//   LOW: rise -> HIGH, high_cnt=1. low_cnt++; at low_cnt==RESET_DELAY-1 -> frame end, -> IDLE.
//  Byte complete (8th fall): if byte_cnt<=BUFFER_END: wr_en=1, wr_addr=byte_cnt, wr_data=byte, byte_cnt++;
//   else err_overflow=1, no write. wr_en registered: high for exactly one cycle, asserted on 3rd rising clk
//   edge after neoData pin falls (2 sync + 1 register). wr_addr/wr_data hold until next write.
//  Frame end: frame_done pulse 1 cycle, frame_len=byte_cnt (saturates at BUFFER_END+1),
//   err_partial=(bit_cnt!=0). Flags hold until next frame's first rise (IDLE->HIGH).
//  Frame end with 0 bytes and 0 bits impossible (only reached from LOW).
//  enable=0: synchronous return to WAIT_SYNC next edge, wr_en forced 0, partial data discarded, flags held.
//  Continuous line high in IDLE/WAIT_SYNC: no action; HIGH entered only on rise.
//  byte_cnt never wraps; overflow bytes dropped, not written to address 0.
// TESTING
//  1 reset; low 320 ticks; bytes A5,0F,FF (T0H=3,T1H=5,period 8); low 320 -> writes @0:A5 @1:0F @2:FF, frame_done, frame_len=3, errs 0.
//  2 after reset drive 0x55 with no preceding sync -> no wr_en; then 320 low + 0x55 -> single write @0:55.
//  3 high widths 3,4,11 -> bits 0,1,1; high 12 ticks -> err_timing=1, no write, no frame_done, resync needed.
//  4 12 bits (0xC3 + 4 bits) then 320 low -> one write @0:C3, frame_len=1, err_partial=1.
//  5 BUFFER_END=3, 6 bytes -> writes @0..3 only, err_overflow=1, frame_len=4; next frame clears flag.
//  6 reset mid-byte, and enable=0 mid-byte -> wr_en stays 0, outputs/state per reset rules; loopback vs transmitter matches buffer.

Source files
------------

// File: rtl/anton_neopixel_receiver.sv
// WS2812-style single-wire decoder: classifies high-pulse widths into bits, packs
// MSB-first bytes and streams them into a byte buffer through a simple write port.
module anton_neopixel_receiver #(
  parameter int  BUFFER_END  = 191,
  parameter int  RESET_DELAY = 320,
  parameter int  THRESHOLD   = 4,
  parameter int  MAX_HIGH    = 12,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   neoData,
  output logic                   wr_en,
  output logic [BUFFER_BITS-1:0] wr_addr,
  output logic [7:0]             wr_data,
  output logic                   frame_done,
  output logic [BUFFER_BITS:0]   frame_len,
  output logic                   err_timing,
  output logic                   err_partial,
  output logic                   err_overflow,
  output logic                   busy
);

  localparam int LOW_W  = $clog2(RESET_DELAY + 1);
  localparam int HIGH_W = $clog2(MAX_HIGH + 1);
  localparam int CNT_W  = BUFFER_BITS + 1;

  localparam logic [LOW_W-1:0]  LOW_LAST  = LOW_W'(RESET_DELAY - 1);
  localparam logic [HIGH_W-1:0] HIGH_LAST = HIGH_W'(MAX_HIGH);
  localparam logic [HIGH_W-1:0] THRESH_V  = HIGH_W'(THRESHOLD);
  localparam logic [CNT_W-1:0]  BUF_SIZE  = CNT_W'(BUFFER_END + 1);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t state, state_nxt;

  logic sync_q, neo_s, neo_d;
  logic rise, fall;

  logic [LOW_W-1:0]  low_cnt,  low_cnt_nxt;
  logic [HIGH_W-1:0] high_cnt, high_cnt_nxt;
  logic [2:0]        bit_cnt,  bit_cnt_nxt;
  logic [6:0]        shift_reg, shift_nxt;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;

  logic                   wr_en_nxt;
  logic [BUFFER_BITS-1:0] wr_addr_nxt;
  logic [7:0]             wr_data_nxt;
  logic                   frame_done_nxt;
  logic [CNT_W-1:0]       frame_len_nxt;
  logic                   err_timing_nxt, err_partial_nxt, err_overflow_nxt;

  logic       new_bit;
  logic [7:0] new_byte;

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk6_4mhz or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b0;
      neo_s  <= 1'b0;
      neo_d  <= 1'b0;
    end else begin
      sync_q <= neoData;
      neo_s  <= sync_q;
      neo_d  <= neo_s;
    end
  end

  assign rise = ~neo_d & neo_s;
  assign fall = neo_d & ~neo_s;

  assign new_bit  = (high_cnt >= THRESH_V);
  assign new_byte = {shift_reg, new_bit};

  always_comb begin
    state_nxt        = state;
    low_cnt_nxt      = low_cnt;
    high_cnt_nxt     = high_cnt;
    bit_cnt_nxt      = bit_cnt;
    shift_nxt        = shift_reg;
    byte_cnt_nxt     = byte_cnt;
    wr_en_nxt        = 1'b0;
    wr_addr_nxt      = wr_addr;
    wr_data_nxt      = wr_data;
    frame_done_nxt   = 1'b0;
    frame_len_nxt    = frame_len;
    err_timing_nxt   = err_timing;
    err_partial_nxt  = err_partial;
    err_overflow_nxt = err_overflow;

    if (!enable) begin
      state_nxt   = WAIT_SYNC;
      low_cnt_nxt = '0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        WAIT_SYNC: begin
          if (neo_s) begin
            low_cnt_nxt = '0;
          end else if (low_cnt == LOW_LAST) begin
            low_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            low_cnt_nxt = low_cnt + 1'b1;
          end
        end

        IDLE: begin
          if (rise) begin
            state_nxt        = HIGH;
            high_cnt_nxt     = HIGH_W'(1);
            bit_cnt_nxt      = '0;
            byte_cnt_nxt     = '0;
            err_timing_nxt   = 1'b0;
            err_partial_nxt  = 1'b0;
            err_overflow_nxt = 1'b0;
          end
        end

        HIGH: begin
          // The width check wins over a coincident fall so a pulse of exactly
          // MAX_HIGH ticks is flagged rather than decoded as a 1.
          if (high_cnt == HIGH_LAST) begin
            err_timing_nxt = 1'b1;
            bit_cnt_nxt    = '0;
            low_cnt_nxt    = '0;
            state_nxt      = WAIT_SYNC;
          end else if (fall) begin
            shift_nxt   = {shift_reg[5:0], new_bit};
            bit_cnt_nxt = bit_cnt + 1'b1;
            low_cnt_nxt = LOW_W'(1);
            state_nxt   = LOW;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt != BUF_SIZE) begin
                wr_en_nxt    = 1'b1;
                wr_addr_nxt  = byte_cnt[BUFFER_BITS-1:0];
                wr_data_nxt  = new_byte;
                byte_cnt_nxt = byte_cnt + 1'b1;
              end else begin
                err_overflow_nxt = 1'b1;
              end
            end
          end else begin
            high_cnt_nxt = high_cnt + 1'b1;
          end
        end

        LOW: begin
          if (rise) begin
            state_nxt    = HIGH;
            high_cnt_nxt = HIGH_W'(1);
          end else if (low_cnt == LOW_LAST) begin
            state_nxt       = IDLE;
            low_cnt_nxt     = '0;
            frame_done_nxt  = 1'b1;
            frame_len_nxt   = byte_cnt;
            err_partial_nxt = (bit_cnt != 3'd0);
            bit_cnt_nxt     = '0;
          end else begin
            low_cnt_nxt = low_cnt + 1'b1;
          end
        end

        default: state_nxt = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk6_4mhz or posedge reset) begin
    if (reset) begin
      state        <= WAIT_SYNC;
      low_cnt      <= '0;
      high_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      byte_cnt     <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_done   <= 1'b0;
      frame_len    <= '0;
      err_timing   <= 1'b0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      low_cnt      <= low_cnt_nxt;
      high_cnt     <= high_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift_reg    <= shift_nxt;
      byte_cnt     <= byte_cnt_nxt;
      wr_en        <= wr_en_nxt;
      wr_addr      <= wr_addr_nxt;
      wr_data      <= wr_data_nxt;
      frame_done   <= frame_done_nxt;
      frame_len    <= frame_len_nxt;
      err_timing   <= err_timing_nxt;
      err_partial  <= err_partial_nxt;
      err_overflow <= err_overflow_nxt;
    end
  end

  assign busy = (state == HIGH) || (state == LOW);

endmodule

// File: tb/tb_anton_neopixel_receiver.sv
// Directed bench for anton_neopixel_receiver with a 4-byte buffer (BUFFER_END=3).
`timescale 1ns/1ps
module tb_anton_neopixel_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       neoData = 1'b0;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;
  logic [2:0] frame_len;
  logic       err_timing, err_partial, err_overflow, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] wq_addr[$];
  logic [7:0] wq_data[$];
  int         fd_cnt = 0;
  logic [2:0] fd_len = '0;

  anton_neopixel_receiver #(.BUFFER_END(3)) dut (
    .clk6_4mhz(clk), .reset(reset), .enable(enable), .neoData(neoData),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_len(frame_len),
    .err_timing(err_timing), .err_partial(err_partial),
    .err_overflow(err_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_len = frame_len;
    end
  end

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    fd_cnt = 0;
  endtask

  task automatic pulse(input int h, input int l);
    neoData = 1'b1;
    repeat (h) @(negedge clk);
    neoData = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(5, 3);
    else   pulse(3, 5);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic line_low(input int n);
    neoData = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    neoData = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    neoData = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    n_checks++; if (wr_addr !== 2'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    n_checks++; if (frame_len !== 3'd0) begin n_fail++; $display("FAIL reset_frame_len got %0d want 0", frame_len); end
    n_checks++; if ({frame_done, err_timing, err_partial, err_overflow, busy} !== 5'b0)
      begin n_fail++; $display("FAIL reset_flags got %b want 00000", {frame_done, err_timing, err_partial, err_overflow, busy}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame();
    clear_mon();
    line_low(330);
    send_byte(8'hA5);
    send_byte(8'h0F);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    neoData = 1'b1;
    repeat (5) @(negedge clk);
    neoData = 1'b0;
    // pin falls here: strobe expected after the 3rd rising edge only
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL lat_edge1 got %b want 0", wr_en); end
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL lat_edge2 got %b want 0", wr_en); end
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL lat_edge3 got %b want 1", wr_en); end
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL lat_edge4 got %b want 0", wr_en); end
    n_checks++; if (wr_data !== 8'hFF) begin n_fail++; $display("FAIL lat_hold_data got %h want ff", wr_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy got %b want 1", busy); end
    line_low(336);
    n_checks++; if (wq_addr.size() !== 3) begin n_fail++; $display("FAIL frame_nwrites got %0d want 3", wq_addr.size()); end
    if (wq_addr.size() == 3) begin
      n_checks++; if ({wq_addr[0], wq_data[0]} !== {2'd0, 8'hA5}) begin n_fail++; $display("FAIL frame_w0 got %0d:%h want 0:a5", wq_addr[0], wq_data[0]); end
      n_checks++; if ({wq_addr[1], wq_data[1]} !== {2'd1, 8'h0F}) begin n_fail++; $display("FAIL frame_w1 got %0d:%h want 1:0f", wq_addr[1], wq_data[1]); end
      n_checks++; if ({wq_addr[2], wq_data[2]} !== {2'd2, 8'hFF}) begin n_fail++; $display("FAIL frame_w2 got %0d:%h want 2:ff", wq_addr[2], wq_data[2]); end
    end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_done_cnt got %0d want 1", fd_cnt); end
    n_checks++; if (frame_len !== 3'd3) begin n_fail++; $display("FAIL frame_len got %0d want 3", frame_len); end
    n_checks++; if ({err_timing, err_partial, err_overflow, busy} !== 4'b0)
      begin n_fail++; $display("FAIL frame_errs got %b want 0000", {err_timing, err_partial, err_overflow, busy}); end
  endtask

  task automatic test_no_sync();
    do_reset();
    clear_mon();
    send_byte(8'h55);
    n_checks++; if (wq_addr.size() !== 0) begin n_fail++; $display("FAIL nosync_write got %0d writes want 0", wq_addr.size()); end
    line_low(340);
    send_byte(8'h55);
    line_low(340);
    n_checks++; if (wq_addr.size() !== 1) begin n_fail++; $display("FAIL nosync_nwrites got %0d want 1", wq_addr.size()); end
    if (wq_addr.size() == 1) begin
      n_checks++; if ({wq_addr[0], wq_data[0]} !== {2'd0, 8'h55}) begin n_fail++; $display("FAIL nosync_w0 got %0d:%h want 0:55", wq_addr[0], wq_data[0]); end
    end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL nosync_done got %0d want 1", fd_cnt); end
  endtask

  task automatic test_timing();
    clear_mon();
    pulse(3, 5);
    pulse(4, 4);
    pulse(11, 4);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    pulse(12, 4);
    n_checks++; if (wq_addr.size() !== 1) begin n_fail++; $display("FAIL timing_nwrites got %0d want 1", wq_addr.size()); end
    if (wq_addr.size() == 1) begin
      n_checks++; if ({wq_addr[0], wq_data[0]} !== {2'd0, 8'h75}) begin n_fail++; $display("FAIL timing_widths got %0d:%h want 0:75", wq_addr[0], wq_data[0]); end
    end
    n_checks++; if (err_timing !== 1'b1) begin n_fail++; $display("FAIL timing_err got %b want 1", err_timing); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timing_busy got %b want 0", busy); end
    send_byte(8'h5A);
    line_low(340);
    n_checks++; if (wq_addr.size() !== 1) begin n_fail++; $display("FAIL timing_resync got %0d writes want 1", wq_addr.size()); end
    n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL timing_nodone got %0d want 0", fd_cnt); end
    n_checks++; if (err_timing !== 1'b1) begin n_fail++; $display("FAIL timing_hold got %b want 1", err_timing); end
    send_byte(8'h3C);
    line_low(340);
    n_checks++; if (wq_addr.size() !== 2) begin n_fail++; $display("FAIL timing_next_nwrites got %0d want 2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      n_checks++; if ({wq_addr[1], wq_data[1]} !== {2'd0, 8'h3C}) begin n_fail++; $display("FAIL timing_next_w got %0d:%h want 0:3c", wq_addr[1], wq_data[1]); end
    end
    n_checks++; if ({fd_cnt, err_timing} !== {32'd1, 1'b0}) begin n_fail++; $display("FAIL timing_next_done got %0d/%b want 1/0", fd_cnt, err_timing); end
  endtask

  task automatic test_partial();
    clear_mon();
    send_byte(8'hC3);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    line_low(340);
    n_checks++; if (wq_addr.size() !== 1) begin n_fail++; $display("FAIL partial_nwrites got %0d want 1", wq_addr.size()); end
    if (wq_addr.size() == 1) begin
      n_checks++; if ({wq_addr[0], wq_data[0]} !== {2'd0, 8'hC3}) begin n_fail++; $display("FAIL partial_w0 got %0d:%h want 0:c3", wq_addr[0], wq_data[0]); end
    end
    n_checks++; if (fd_len !== 3'd1) begin n_fail++; $display("FAIL partial_len got %0d want 1", fd_len); end
    n_checks++; if (err_partial !== 1'b1) begin n_fail++; $display("FAIL partial_err got %b want 1", err_partial); end
  endtask

  task automatic test_enable();
    clear_mon();
    enable = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if ({err_partial, frame_len} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL enable_hold got %b/%0d want 1/1", err_partial, frame_len); end
    enable = 1'b1;
    line_low(340);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n_checks++; if (err_partial !== 1'b0) begin n_fail++; $display("FAIL enable_clear got %b want 0", err_partial); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_busy got %b want 0", busy); end
    enable = 1'b1;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    line_low(340);
    n_checks++; if ({wq_addr.size(), fd_cnt} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL enable_discard got %0d writes %0d done want 0/0", wq_addr.size(), fd_cnt); end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [6];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clear_mon();
    for (int i = 0; i < 6; i++) send_byte(vals[i]);
    line_low(340);
    n_checks++; if (wq_addr.size() !== 4) begin n_fail++; $display("FAIL ovf_nwrites got %0d want 4", wq_addr.size()); end
    if (wq_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if ({wq_addr[i], wq_data[i]} !== {2'(i), vals[i]}) begin n_fail++; $display("FAIL ovf_w%0d got %0d:%h want %0d:%h", i, wq_addr[i], wq_data[i], i, vals[i]); end
      end
    end
    n_checks++; if ({err_overflow, frame_len} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL ovf_flag_len got %b/%0d want 1/4", err_overflow, frame_len); end
    clear_mon();
    send_byte(8'h77);
    line_low(340);
    n_checks++; if ({err_overflow, frame_len} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL ovf_next got %b/%0d want 0/1", err_overflow, frame_len); end
    n_checks++; if (wq_data.size() != 1 || wq_data[0] !== 8'h77) begin n_fail++; $display("FAIL ovf_next_w got %0d writes want one of 77", wq_data.size()); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    neoData = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    neoData = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({wr_en, wr_data, frame_len, busy} !== '0) begin n_fail++; $display("FAIL rstmid_out got %b %h %0d %b want zeros", wr_en, wr_data, frame_len, busy); end
    reset = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    line_low(340);
    n_checks++; if ({wq_addr.size(), fd_cnt} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL rstmid_discard got %0d writes %0d done want 0/0", wq_addr.size(), fd_cnt); end
  endtask

  task automatic test_loopback();
    logic [7:0] tx [4];
    clear_mon();
    for (int i = 0; i < 4; i++) tx[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) send_byte(tx[i]);
    line_low(340);
    n_checks++; if (wq_data.size() !== 4) begin n_fail++; $display("FAIL loop_nwrites got %0d want 4", wq_data.size()); end
    if (wq_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if ({wq_addr[i], wq_data[i]} !== {2'(i), tx[i]}) begin n_fail++; $display("FAIL loop_w%0d got %0d:%h want %0d:%h", i, wq_addr[i], wq_data[i], i, tx[i]); end
      end
    end
    n_checks++; if ({fd_cnt, frame_len, err_overflow} !== {32'd1, 3'd4, 1'b0}) begin n_fail++; $display("FAIL loop_done got %0d/%0d/%b want 1/4/0", fd_cnt, frame_len, err_overflow); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_no_sync();
    test_timing();
    test_partial();
    test_enable();
    test_overflow();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
